// File: rtl/v_axi_arb_pkg.sv
// Shared types and widths for the AXI read arbiter and its round-robin picker.
package v_axi_arb_pkg;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;
    localparam int ARLEN_W     = 8;
    localparam int BEAT_W      = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/v_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module v_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    int unsigned     sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_oh_o    = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        sum         = 0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            sum = 32'(ptr_i) + 32'(i);
            idx = IDX_W'(sum % 32'(N));
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o   = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = idx;
            end
        end
    end

endmodule

// File: rtl/v_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port among NUM_REQ requesters,
// with a single burst outstanding and a sticky burst-length error flag.
module v_axi_rd_arbiter
    import v_axi_arb_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int NUM_REQ            = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_arvalid,
    output logic [NUM_REQ-1:0]                    req_arready,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*ARLEN_W-1:0]            req_arlen,
    output logic [NUM_REQ-1:0]                    req_rvalid,
    input  logic [NUM_REQ-1:0]                    req_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]                    req_rlast,
    output logic                                  v_m_axi_arvalid,
    input  logic                                  v_m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         v_m_axi_araddr,
    output logic [ARLEN_W-1:0]                    v_m_axi_arlen,
    input  logic                                  v_m_axi_rvalid,
    output logic                                  v_m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]         v_m_axi_rdata,
    input  logic                                  v_m_axi_rlast,
    output logic [$clog2(NUM_REQ)-1:0]            grant,
    output logic                                  busy,
    output logic                                  len_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_num_req_check
        $error("v_axi_rd_arbiter: NUM_REQ out of range");
    end

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [ARLEN_W-1:0]      arlen_q, arlen_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    len_err_q, len_err_d;

    logic [NUM_REQ-1:0]      pick_oh;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_valid;
    logic                    beat;

    v_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i       (req_arvalid),
        .ptr_i       (rr_ptr_q),
        .gnt_oh_o    (pick_oh),
        .gnt_idx_o   (pick_idx),
        .gnt_valid_o (pick_valid)
    );

    assign beat = v_m_axi_rvalid & v_m_axi_rready;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d  = pick_idx;
                    araddr_d = req_araddr[pick_idx*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
                    arlen_d  = req_arlen[pick_idx*ARLEN_W +: ARLEN_W];
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (v_m_axi_arready) begin
                    state_d    = ST_DATA;
                    beat_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // The counter holds beats already taken, so the last beat must see arlen.
                    if (v_m_axi_rlast) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                        if (beat_cnt_q != BEAT_W'(arlen_q)) len_err_d = 1'b1;
                    end else if (beat_cnt_q == BEAT_W'(arlen_q)) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_arready     = '0;
        req_rvalid      = '0;
        req_rlast       = '0;
        v_m_axi_arvalid = 1'b0;
        v_m_axi_rready  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (!rst) req_arready = pick_oh;
            ST_ADDR: v_m_axi_arvalid = 1'b1;
            ST_DATA: begin
                v_m_axi_rready      = req_rready[grant_q];
                req_rvalid[grant_q] = v_m_axi_rvalid;
                req_rlast[grant_q]  = v_m_axi_rlast;
            end
            default: ;
        endcase
    end

    assign v_m_axi_araddr = araddr_q;
    assign v_m_axi_arlen  = arlen_q;
    assign req_rdata      = v_m_axi_rdata;
    assign grant          = grant_q;
    assign busy           = (state_q != ST_IDLE);
    assign len_err        = len_err_q;

endmodule
